// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and sizing helpers for the synchronous FIFO, used by both
// the RTL and its testbench so the two always agree on pointer/count widths.
//   FIFO_WIDTH_DEF : default data word width
//   FIFO_DEPTH_DEF : default number of storage entries
//   fifoPtrW()     : address/pointer width for a given depth
//   fifoCntW()     : occupancy counter width (must represent 0..depth)
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 16;

  // Pointer width: depth is a power of two, so pointers wrap naturally.
  function automatic int fifoPtrW(input int depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit so that "completely full" is representable.
  function automatic int fifoCntW(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// DEPTH x WIDTH storage array with one synchronous write port and one
// synchronous read port. No reset: contents are don't-care until written.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable, loads rdata_o on the edge
//   raddr_i : read address
//   rdata_o : registered read data, holds when re_i is low
// ---------------------------------------------------------------------------
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write and read ports share a clock. The controller only enables both
  // on the same address when the FIFO is empty or full, and in those cases
  // one of the two requests is always rejected, so no read-during-write
  // ordering question arises.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count, threshold flags and sticky
// overflow/underflow error flags. Storage lives in fifo_mem; this module
// holds pointers, count and error state.
//   clk, rst       : clock, asynchronous active-high reset
//   push, data_i   : write request and data (accepted when not full)
//   pop, data_o    : read request (accepted when not empty), registered data
//   full, empty    : count == DEPTH / count == 0
//   almost_full    : count >= AF_LEVEL
//   almost_empty   : count <= AE_LEVEL
//   count          : occupancy 0..DEPTH
//   overflow       : sticky, set by a rejected push
//   underflow      : sticky, set by a rejected pop
//   clr_err        : synchronous clear of both error flags
// ---------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          data_i,
  output logic                      full,
  input  logic                      pop,
  output logic [WIDTH-1:0]          data_o,
  output logic                      empty,
  output logic [fifoCntW(DEPTH)-1:0] count,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int PW = fifoPtrW(DEPTH);
  localparam int CW = fifoCntW(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rdValid_q, rdValid_d;
  logic             pushOk, popOk;
  logic [WIDTH-1:0] memRdata;

  // Status flags decode the count register only, so they never see a
  // combinational path from push/pop.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses the pre-edge flags, so a push into a full FIFO is
  // rejected even if a pop frees a slot on the same edge (and vice versa).
  assign pushOk = push && !full;
  assign popOk  = pop && !empty;

  // Next-state for pointers, count and error flags. Pointers wrap for free
  // because DEPTH is a power of two. A new error wins over clr_err in the
  // same cycle so no event is ever silently lost.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    rdValid_d   = rdValid_q;
    overflow_d  = overflow_q && !clr_err;
    underflow_d = underflow_q && !clr_err;

    if (pushOk) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (popOk) begin
      rdPtr_d   = rdPtr_q + PW'(1);
      rdValid_d = 1'b1;
    end

    case ({pushOk, popOk})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push && full) begin
      overflow_d = 1'b1;
    end
    if (pop && empty) begin
      underflow_d = 1'b1;
    end
  end

  // State registers. Reset empties the FIFO immediately; memory contents
  // are left alone since the pointers make them unreachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rdValid_q   <= rdValid_d;
    end
  end

  // The memory read register has no reset, so data_o is forced to zero
  // until the first accepted pop after reset loads it with real data.
  assign data_o = rdValid_q ? memRdata : '0;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) uMem (
    .clk     (clk),
    .we_i    (pushOk),
    .waddr_i (wrPtr_q),
    .wdata_i (data_i),
    .re_i    (popOk),
    .raddr_i (rdPtr_q),
    .rdata_o (memRdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
// Self-checking bench for sync_fifo: a table of single-cycle vectors plus
// hand-written multi-cycle sequences for fill/drain, overflow, steady-state
// streaming with pointer wrap, and asynchronous reset mid-operation.
// ---------------------------------------------------------------------------
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int W  = FIFO_WIDTH_DEF;
  localparam int D  = FIFO_DEPTH_DEF;
  localparam int CW = fifoCntW(FIFO_DEPTH_DEF);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic [W-1:0]  data_o;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic          push;
    logic          pop;
    logic          clr;
    logic [W-1:0]  din;
    logic [CW-1:0] expCount;
    logic [W-1:0]  expData;
    logic          expOvf;
    logic          expUnf;
  } vec_t;

  vec_t vecs[$];

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .data_i       (data_i),
    .full         (full),
    .pop          (pop),
    .data_o       (data_o),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Compare count, data and the flag bundle; threshold flags are derived
  // from the expected count with the default levels 14 and 2.
  task automatic checkOutput(input string nm, input logic [CW-1:0] expCount,
                             input logic [W-1:0] expData, input logic expOvf,
                             input logic expUnf);
    logic [5:0] expFlags;
    logic [5:0] actFlags;
    expFlags = {(expCount == CW'(D)), (expCount == '0), (expCount >= CW'(14)),
                (expCount <= CW'(2)), expOvf, expUnf};
    actFlags = {full, empty, almost_full, almost_empty, overflow, underflow};
    checkVal({nm, " count"}, 32'(count), 32'(expCount));
    checkVal({nm, " data_o"}, 32'(data_o), 32'(expData));
    checkVal({nm, " flags"}, 32'(actFlags), 32'(expFlags));
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 unit later.
  task automatic applyStimulus(input logic p, input logic q, input logic c, input logic [W-1:0] d);
    push    = p;
    pop     = q;
    clr_err = c;
    data_i  = d;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    data_i  = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Single-cycle vectors starting from reset:
    //   push, pop, clr, din, count, data_o, ovf, unf
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hA1, 5'd1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hA2, 5'd2, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 8'hA3, 5'd3, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 8'hA1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 8'hA1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hB1, 5'd2, 8'hA2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 8'hA3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'hB1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'hB1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 8'hB1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 8'hB1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 8'hB1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hC4, 5'd1, 8'hB1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 5'd1, 8'hB1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 8'hC4, 1'b0, 1'b0});

    // Reset state
    #2;
    checkOutput("reset", 5'd0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset held", 5'd0, 8'h00, 1'b0, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expData,
                  vecs[i].expOvf, vecs[i].expUnf);
    end

    // Fill to full, then overflow, then push+pop while full, then drain
    doReset();
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
      checkOutput($sformatf("fill%0d", i), 5'(i + 1), 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hAA);
    checkOutput("overflow push", 5'd16, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("clr overflow", 5'd16, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hBB);
    checkOutput("push+pop full", 5'd15, 8'h11, 1'b1, 1'b0);
    for (int i = 1; i < D; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput($sformatf("drain%0d", i), 5'(15 - i), 8'(8'h11 + i), 1'b1, 1'b0);
    end

    // Empty pop: underflow, data held, then clear
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    checkOutput("empty pop", 5'd0, 8'h20, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("clr underflow", 5'd0, 8'h20, 1'b0, 1'b0);

    // Steady streaming at count 5 across two pointer wraps
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    end
    checkOutput("prefill5", 5'd5, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(8'h45 + i));
      checkOutput($sformatf("stream%0d", i), 5'd5, 8'(8'h40 + i), 1'b0, 1'b0);
    end

    // Asynchronous reset between edges with 9 entries stored
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("pre-reset", 5'd9, 8'h60, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset", 5'd0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h33);
    checkOutput("post-reset push", 5'd1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("post-reset pop", 5'd0, 8'h33, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
